// File: rtl/cnn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared CNN datapath widths, default feature-map geometry and
//               the 2x2 pooling window phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int C_PE_IN_W  = 8;
    localparam int C_PE_WGT_W = 8;
    localparam int C_PE_ACC_W = 16;

    localparam int C_DATA_W = C_PE_ACC_W;
    localparam int C_MAP_W  = 24;
    localparam int C_MAP_H  = 24;

    // Encoded as {row[0], col[0]} of the sample being accepted.
    typedef enum logic [1:0] {
        PH_EVEN_EVEN = 2'b00,
        PH_EVEN_ODD  = 2'b01,
        PH_ODD_EVEN  = 2'b10,
        PH_ODD_ODD   = 2'b11
    } pool_phase_t;

endpackage
`default_nettype wire

// File: rtl/pool_line_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pool_line_buf
// Description : Simple dual-port RAM holding one row of horizontal pair maxima;
//               synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf #(
    parameter int DEPTH  = 12,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/relu_maxpool2x2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : relu_maxpool2x2
// Description : Streaming ReLU followed by 2x2 max pooling over a raster-order
//               feature map; one pooled word per completed window.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_maxpool2x2
    import cnn_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int MAP_W  = C_MAP_W,
    parameter int MAP_H  = C_MAP_H
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] pool_data,
    output logic              pool_valid,
    output logic              frame_done
);

    localparam int COL_W    = (MAP_W > 2) ? $clog2(MAP_W) : 1;
    localparam int ROW_W    = (MAP_H > 2) ? $clog2(MAP_H) : 1;
    localparam int LB_DEPTH = MAP_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_pool_data;
    logic              r_pool_valid;
    logic              r_frame_done;

    logic [DATA_W-1:0] w_relu;
    logic [DATA_W-1:0] w_lb_rdata;
    logic [DATA_W-1:0] w_lb_wdata;
    logic [LB_AW-1:0]  w_lb_addr;
    logic              w_lb_we;
    logic              w_last_col;
    logic              w_last_row;
    pool_phase_t       w_phase;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_relu     = in_data[DATA_W-1] ? '0 : in_data;
    assign w_phase    = pool_phase_t'({r_row[0], r_col[0]});
    assign w_last_col = (r_col == COL_W'(MAP_W - 1));
    assign w_last_row = (r_row == ROW_W'(MAP_H - 1));
    assign w_lb_addr  = LB_AW'(r_col >> 1);
    assign w_lb_wdata = umax(r_hold, w_relu);
    // Line buffer is not reset, but a sample swallowed by rst/clr must not land in it.
    assign w_lb_we    = in_valid && !clr && !rst && (w_phase == PH_EVEN_ODD);

    pool_line_buf #(
        .DEPTH  (LB_DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_addr),
        .i_wdata (w_lb_wdata),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_pool_data  <= '0;
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_pool_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (clr) begin
                r_col  <= '0;
                r_row  <= '0;
                r_hold <= '0;
            end else if (in_valid) begin
                case (w_phase)
                    PH_EVEN_EVEN: r_hold <= w_relu;
                    PH_EVEN_ODD:  ;
                    PH_ODD_EVEN:  r_hold <= umax(w_lb_rdata, w_relu);
                    PH_ODD_ODD: begin
                        r_pool_data  <= umax(r_hold, w_relu);
                        r_pool_valid <= 1'b1;
                        r_frame_done <= w_last_col && w_last_row;
                    end
                endcase

                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign pool_data  = r_pool_data;
    assign pool_valid = r_pool_valid;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2x2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_relu_maxpool2x2
// Description : Self-checking bench: directed 4x2 windows plus randomized 24x24
//               frames scored against a whole-frame pooling model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool2x2;

    localparam int W  = 16;
    localparam int BW = 24;
    localparam int BH = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clr, in_valid;
    logic [W-1:0] in_data;
    logic [W-1:0] pool_data;
    logic         pool_valid, frame_done;

    logic         s_clr, s_in_valid;
    logic [W-1:0] s_in_data;
    logic [W-1:0] s_pool_data;
    logic         s_pool_valid, s_frame_done;

    relu_maxpool2x2 #(.DATA_W(W), .MAP_W(BW), .MAP_H(BH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .pool_data(pool_data), .pool_valid(pool_valid), .frame_done(frame_done)
    );

    relu_maxpool2x2 #(.DATA_W(W), .MAP_W(4), .MAP_H(2)) dut_small (
        .clk(clk), .rst(rst), .clr(s_clr), .in_data(s_in_data), .in_valid(s_in_valid),
        .pool_data(s_pool_data), .pool_valid(s_pool_valid), .frame_done(s_frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: keep the rectified frame, pool each window once its
    // bottom-right sample arrives.
    logic [W-1:0] img [BH][BW];
    int           mrow = 0, mcol = 0;
    logic [W:0]   exp_q [$];
    int           pv_cnt = 0, fd_cnt = 0;

    function automatic logic [W-1:0] relu(input logic [W-1:0] x);
        return x[W-1] ? '0 : x;
    endfunction

    task automatic model_accept(input logic [W-1:0] x);
        logic [W-1:0] m;
        img[mrow][mcol] = relu(x);
        if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
            m = '0;
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++)
                    if (img[mrow-dr][mcol-dc] > m) m = img[mrow-dr][mcol-dc];
            exp_q.push_back({(mrow == BH-1 && mcol == BW-1), m});
        end
        mcol++;
        if (mcol == BW) begin
            mcol = 0;
            mrow++;
            if (mrow == BH) mrow = 0;
        end
    endtask

    always @(negedge clk) begin
        logic [W:0] e;
        if (pool_valid) begin
            pv_cnt++;
            if (frame_done) fd_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_pool_valid", pool_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("pool_data", pool_data, e[W-1:0]);
                check("frame_done", frame_done, e[W]);
            end
        end else if (frame_done) begin
            check("frame_done_without_valid", frame_done, 1'b0);
        end
    end

    logic [W:0] s_got [$];
    always @(negedge clk) begin
        if (s_pool_valid) s_got.push_back({s_frame_done, s_pool_data});
    end

    task automatic send(input logic [W-1:0] x, input int max_gap);
        int g;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_data  = x;
        in_valid = 1'b1;
        model_accept(x);
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < BW*BH; i++) send(W'($urandom), max_gap);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic small_frame(input logic [W-1:0] v [8], input logic [W-1:0] e0,
                               input logic [W-1:0] e1, input string tag);
        logic [W:0] g;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_in_data  = v[i];
            s_in_valid = 1'b1;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_count"}, s_got.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (s_got.size() != 0) begin
                g = s_got.pop_front();
                check({tag, "_data"}, g[W-1:0], (i == 0) ? e0 : e1);
                check({tag, "_done"}, g[W], (i == 1));
            end
        end
        s_got.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v [8];
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
        s_clr = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
        repeat (3) @(negedge clk);
        check("reset_pool_data", pool_data, 0);
        check("reset_pool_valid", pool_valid, 0);
        check("reset_frame_done", frame_done, 0);
        rst = 1'b0;

        v = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        small_frame(v, 16'd6, 16'd8, "basic");
        check("hold_when_idle", {s_pool_valid, s_pool_data}, {1'b0, 16'd8});

        v = '{default: 16'hFFF0};
        small_frame(v, 16'd0, 16'd0, "negative");

        v = '{16'h7FFF, 16'h8000, 16'd5, 16'd3, 16'd0, 16'd1, 16'd2, 16'd4};
        small_frame(v, 16'h7FFF, 16'd5, "unsigned_max");

        send_frame(2);
        send_frame(0);
        drain();
        check("b2b_pool_count", pv_cnt, 2*(BW/2)*(BH/2));
        check("b2b_frame_done_count", fd_cnt, 2);
        pv_cnt = 0; fd_cnt = 0;

        for (int i = 0; i < 10; i++) send(W'($urandom), 1);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'h7FFE;
        mrow = 0; mcol = 0;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        send_frame(1);
        drain();
        check("clr_pool_count", pv_cnt, (BW/2)*(BH/2));
        check("clr_frame_done_count", fd_cnt, 1);

        for (int i = 0; i < BW + 5; i++) send(W'($urandom), 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h7FFE;
        @(negedge clk);
        check("midrst_pool_data", pool_data, 0);
        check("midrst_pool_valid", pool_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        rst = 1'b0; in_valid = 1'b0;
        mrow = 0; mcol = 0;
        pv_cnt = 0; fd_cnt = 0;
        send_frame(1);
        drain();
        check("rst_pool_count", pv_cnt, (BW/2)*(BH/2));
        check("rst_frame_done_count", fd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
